elevator_call_scheduler: RTL

//   Latches floor-call buttons and picks the next target floor for the elevator car with a SCAN policy:
//   - keeps the current direction while calls remain ahead of the car, then reverses.
//   - target_floor drives the car state machine's requested_floor input.
//   - the car state machine's current_floor and idle flag feed back in.

---
 rtl/elevator_call_scheduler_if.sv | 25 ++
 rtl/elevator_call_scheduler.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler_if.sv
// Call-scheduler bus: call buttons and car feedback in, target command and lamps out.
// The scheduler uses the master modport; the car/button side uses slave.
interface elevator_call_scheduler_if #(
    parameter int unsigned NUM_FLOORS = 9,
    parameter int unsigned FLOOR_W    = 4
);
    logic [NUM_FLOORS-1:0] call_req;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  car_idle;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  target_valid;
    logic                  dir_up;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] call_pending;

    modport master (
        input  call_req, current_floor, car_idle,
        output target_floor, target_valid, dir_up, door_open, call_pending
    );

    modport slave (
        output call_req, current_floor, car_idle,
        input  target_floor, target_valid, dir_up, door_open, call_pending
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// SCAN elevator call scheduler: latches calls, picks targets, times door dwell.
// Optional SCHED_RETARGET_EN: retarget mid-trip to a nearer in-path call.
module elevator_call_scheduler #(
    parameter int unsigned NUM_FLOORS  = 9,
    parameter int unsigned FLOOR_W     = 4,
    parameter int unsigned DOOR_CYCLES = 20
) (
    input logic                       clk,
    input logic                       rst,
    elevator_call_scheduler_if.master bus
);

    localparam int unsigned TimerW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TimerW-1:0] DoorLoad = TimerW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSelect, StTravel, StDoor} state_e;

    state_e                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic                  dir_up_q, dir_up_d;
    logic [TimerW-1:0]     timer_q, timer_d;
    logic                  target_valid_q, target_valid_d;
    logic                  door_open_q, door_open_d;

    logic [NUM_FLOORS-1:0] cur_mask, tgt_mask;
    logic                  has_above, has_below, at_call, arrived;
    logic [FLOOR_W-1:0]    lowest_above, highest_below;

    // Nearest pending call on each side of the car, plus one-hot masks of car and target floors.
    // An out-of-range current_floor yields an empty cur_mask, i.e. no call at the car.
    always_comb begin
        has_above     = 1'b0;
        has_below     = 1'b0;
        lowest_above  = '0;
        highest_below = '0;
        cur_mask      = '0;
        tgt_mask      = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) == bus.current_floor) cur_mask[i] = 1'b1;
            if (FLOOR_W'(i) == target_q)          tgt_mask[i] = 1'b1;
            if (pending_q[i] && (FLOOR_W'(i) > bus.current_floor) && !has_above) begin
                has_above    = 1'b1;
                lowest_above = FLOOR_W'(i);
            end
            if (pending_q[i] && (FLOOR_W'(i) < bus.current_floor)) begin
                has_below     = 1'b1;
                highest_below = FLOOR_W'(i);
            end
        end
        at_call = |(pending_q & cur_mask);
        arrived = bus.car_idle && (bus.current_floor == target_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            pending_q      <= '0;
            target_q       <= '0;
            dir_up_q       <= 1'b1;
            timer_q        <= '0;
            target_valid_q <= 1'b0;
            door_open_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            target_q       <= target_d;
            dir_up_q       <= dir_up_d;
            timer_q        <= timer_d;
            target_valid_q <= target_valid_d;
            door_open_q    <= door_open_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        dir_up_d  = dir_up_q;
        timer_d   = timer_q;
        pending_d = pending_q | bus.call_req;
        unique case (state_q)
            StIdle: begin
                if (|pending_q) state_d = StSelect;
            end
            StSelect: begin
                if (at_call) begin
                    state_d   = StDoor;
                    timer_d   = DoorLoad;
                    pending_d = pending_d & ~cur_mask;
                end else if (dir_up_q && has_above) begin
                    state_d  = StTravel;
                    target_d = lowest_above;
                end else if (!dir_up_q && has_below) begin
                    state_d  = StTravel;
                    target_d = highest_below;
                end else if (has_above) begin
                    // Nothing left ahead: reverse in this same cycle.
                    state_d  = StTravel;
                    dir_up_d = 1'b1;
                    target_d = lowest_above;
                end else if (has_below) begin
                    state_d  = StTravel;
                    dir_up_d = 1'b0;
                    target_d = highest_below;
                end else begin
                    state_d = StIdle;
                end
            end
            StTravel: begin
                if (arrived) begin
                    state_d   = StDoor;
                    timer_d   = DoorLoad;
                    pending_d = pending_d & ~tgt_mask;
                end
`ifdef SCHED_RETARGET_EN
                else if (dir_up_q && has_above && (lowest_above < target_q)) begin
                    target_d = lowest_above;
                end else if (!dir_up_q && has_below && (highest_below > target_q)) begin
                    target_d = highest_below;
                end
`endif
            end
            StDoor: begin
                // Calls at the open-door floor are absorbed rather than re-opening it.
                pending_d = pending_d & ~cur_mask;
                if (timer_q == '0) begin
                    state_d = StSelect;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        target_valid_d = (state_d == StTravel);
        door_open_d    = (state_d == StDoor);
    end

    always_comb begin
        bus.target_floor = target_q;
        bus.target_valid = target_valid_q;
        bus.dir_up       = dir_up_q;
        bus.door_open    = door_open_q;
        bus.call_pending = pending_q;
    end

endmodule
